// File: rtl/tl_pkg.sv
// Shared definitions for the main/side intersection controller family:
// light FSM state encoding and the default timing constants used by the
// request conditioner, the light controller and the timer.
package tl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam int DEF_DEBOUNCE_CYC = 3;
   localparam int DEF_HOLDOFF_CYC  = 10;
   localparam int DEF_CNT_W        = 4;

endpackage

// File: rtl/side_req_if.sv
// Handshake bundle between the side-road detector front end and the light
// controller. The slave modport is the conditioner's view, the master
// modport is the controller/environment view.
// Optional pedestrian button lines appear when PED_BTN_EN is defined.
interface side_req_if
   import tl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) ();

   logic             sensor_raw;
   logic             ack;
   logic             req;
   logic [CNT_W-1:0] pend_cnt;
   logic             holdoff;
   logic             sat;
`ifdef PED_BTN_EN
   logic             ped_btn;
   logic             ped_pend;

   modport slave (
      input  sensor_raw, ack, ped_btn,
      output req, pend_cnt, holdoff, sat, ped_pend
   );

   modport master (
      output sensor_raw, ack, ped_btn,
      input  req, pend_cnt, holdoff, sat, ped_pend
   );
`else
   modport slave (
      input  sensor_raw, ack,
      output req, pend_cnt, holdoff, sat
   );

   modport master (
      output sensor_raw, ack,
      input  req, pend_cnt, holdoff, sat
   );
`endif

endinterface

// File: rtl/debounce_filter.sv
// Two-flop synchronizer followed by a stability counter. The debounced level
// follows the synchronized input only after it has disagreed for
// DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
// rise is a registered one-cycle pulse on each 0->1 change of dout.
module debounce_filter
   import tl_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise
);

   localparam logic [3:0] STAB_LAST = 4'(DEBOUNCE_CYC - 1);

   logic       sync1;
   logic       sync2;
   logic [3:0] stab_cnt;

   // Bring the asynchronous input into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // Count consecutive disagreement cycles and commit the new level on the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stab_cnt <= 4'd0;
         dout     <= 1'b0;
         rise     <= 1'b0;
      end else begin
         rise <= 1'b0;
         if (sync2 != dout) begin
            if (stab_cnt == STAB_LAST) begin
               dout     <= sync2;
               rise     <= sync2;
               stab_cnt <= 4'd0;
            end else begin
               stab_cnt <= stab_cnt + 4'd1;
            end
         end else begin
            stab_cnt <= 4'd0;
         end
      end
   end

endmodule

// File: rtl/side_req_conditioner.sv
// Side-road request conditioner: turns the raw loop detector into a latched
// request for the light FSM, enforces a hold-off window after each service
// and counts detections that arrive while the request cannot be raised.
// Optional feature macro: PED_BTN_EN adds a pedestrian button whose
// detections also raise the request and set a sticky ped_pend indicator.
module side_req_conditioner
   import tl_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int HOLDOFF_CYC  = DEF_HOLDOFF_CYC,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   side_req_if.slave  bus
);

   localparam logic [CNT_W-1:0] PEND_MAX  = '1;
   localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);
   localparam logic [7:0]       HOLD_LOAD = 8'(HOLDOFF_CYC);

   logic             sens_db;
   logic             sens_rise;
   logic             det_pulse;

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       hold_cnt;
   logic [7:0]       hold_nxt;
   logic [CNT_W-1:0] pend_q;
   logic [CNT_W-1:0] pend_nxt;
   logic [CNT_W-1:0] pend_inc;
   logic             sat_q;
   logic             sat_nxt;
   logic             ack_taken;
   logic             req_q;
   logic             holdoff_q;

   debounce_filter #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_sens_db (
      .clk  (clk),
      .rst  (rst),
      .din  (bus.sensor_raw),
      .dout (sens_db),
      .rise (sens_rise)
   );

`ifdef PED_BTN_EN
   logic ped_db;
   logic ped_rise;
   logic ped_pend_q;

   debounce_filter #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_ped_db (
      .clk  (clk),
      .rst  (rst),
      .din  (bus.ped_btn),
      .dout (ped_db),
      .rise (ped_rise)
   );

   assign det_pulse = sens_rise | ped_rise;

   // Pedestrian indicator: a new press wins over a same-cycle service acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ped_pend_q <= 1'b0;
      end else if (ped_rise) begin
         ped_pend_q <= 1'b1;
      end else if (ack_taken) begin
         ped_pend_q <= 1'b0;
      end
   end

   assign bus.ped_pend = ped_pend_q;
`else
   assign det_pulse = sens_rise;
`endif

   assign pend_inc = (pend_q == PEND_MAX) ? PEND_MAX : pend_q + PEND_ONE;

   // Next-state logic: request latching, service acceptance and hold-off countdown.
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      pend_nxt  = pend_q;
      sat_nxt   = sat_q;
      ack_taken = 1'b0;
      case (state)
         S_IDLE: begin
            if (det_pulse) begin
               state_nxt = S_REQ;
               pend_nxt  = PEND_ONE;
            end
         end
         S_REQ: begin
            if (bus.ack) begin
               ack_taken = 1'b1;
               state_nxt = S_HOLD;
               pend_nxt  = det_pulse ? PEND_ONE : '0;
               sat_nxt   = 1'b0;
               hold_nxt  = HOLD_LOAD;
            end else if (det_pulse) begin
               pend_nxt = pend_inc;
               if (pend_inc == PEND_MAX) begin
                  sat_nxt = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (det_pulse) begin
               pend_nxt = pend_inc;
               if (pend_inc == PEND_MAX) begin
                  sat_nxt = 1'b1;
               end
            end
            if (hold_cnt <= 8'd1) begin
               hold_nxt  = 8'd0;
               state_nxt = ((pend_nxt != '0) || sens_db) ? S_REQ : S_IDLE;
            end else begin
               hold_nxt = hold_cnt - 8'd1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            hold_nxt  = 8'd0;
            pend_nxt  = '0;
            sat_nxt   = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs derived from the upcoming state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         hold_cnt  <= 8'd0;
         pend_q    <= '0;
         sat_q     <= 1'b0;
         req_q     <= 1'b0;
         holdoff_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_nxt;
         pend_q    <= pend_nxt;
         sat_q     <= sat_nxt;
         req_q     <= (state_nxt == S_REQ);
         holdoff_q <= (state_nxt == S_HOLD);
      end
   end

   assign bus.req      = req_q;
   assign bus.pend_cnt = pend_q;
   assign bus.holdoff  = holdoff_q;
   assign bus.sat      = sat_q;

endmodule
